first_zero: RTL and testbench

- Registered lowest-index zero-bit finder over a 64-bit occupancy bitmap, used by the MMU free-block allocator.
- Each cycle it samples `data_in` and reports whether any bit is 0, the index of the lowest 0 bit, and a one-hot mask of that bit.
- The allocator ORs the mask into its bitmap to claim the slot.
- Purely combinational search followed by a single output register stage.

---
 rtl/first_zero.sv | 85 ++++++++
 tb/tb_first_zero.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/first_zero.sv
// Registered lowest-index zero-bit finder for the MMU free-block allocator.
// Optional macro FIRST_ZERO_UPDATED_OUT_EN adds updated_out (bitmap with slot claimed).
module first_zero #(
  parameter int DATA_WIDTH = 64,
  parameter int POS_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  find_success,
  output logic [POS_WIDTH-1:0]  pos_out,
`ifdef FIRST_ZERO_UPDATED_OUT_EN
  output logic [DATA_WIDTH-1:0] updated_out,
`endif
  output logic [DATA_WIDTH-1:0] mask_out
);

  localparam int RAW_NG = (DATA_WIDTH + 7) / 8;
  localparam int GIW    = (RAW_NG > 1) ? $clog2(RAW_NG) : 1;
  localparam int NG     = 2 ** GIW;
  localparam int PW     = NG * 8;
  localparam int IW     = GIW + 3;

  logic [PW-1:0]     pad;
  logic [NG-1:0]     grp_zero;
  logic [2:0]        loc [NG];
  logic [GIW-1:0]    grp_sel;
  logic [IW-1:0]     idx;
  logic              found;
  logic [DATA_WIDTH-1:0] mask;
  logic [POS_WIDTH-1:0]  pos;

  // Unused upper lanes read as occupied so they never win the search.
  always_comb begin
    pad = '1;
    pad[DATA_WIDTH-1:0] = data_in;
  end

  always_comb begin
    for (int g = 0; g < NG; g++) begin
      grp_zero[g] = ~&pad[g*8 +: 8];
      loc[g] = '0;
      for (int b = 7; b >= 0; b--) begin
        if (!pad[g*8 + b]) loc[g] = 3'(b);
      end
    end
  end

  always_comb begin
    grp_sel = '0;
    for (int g = NG - 1; g >= 0; g--) begin
      if (grp_zero[g]) grp_sel = GIW'(g);
    end
    found = |grp_zero;
    idx   = {grp_sel, loc[grp_sel]};
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      mask[i] = found && (idx == IW'(i));
    end
    pos = found ? POS_WIDTH'(idx) : POS_WIDTH'(DATA_WIDTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      find_success <= 1'b0;
      pos_out      <= '0;
      mask_out     <= '0;
    end else begin
      find_success <= found;
      pos_out      <= pos;
      mask_out     <= mask;
    end
  end

`ifdef FIRST_ZERO_UPDATED_OUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) updated_out <= '0;
    else        updated_out <= data_in | mask;
  end
`endif

endmodule

// File: tb/tb_first_zero.sv
// Directed and random checks of first_zero: latency, priority, reset.
// Expected values are hand-computed or from a bit-serial reference loop.
module tb_first_zero;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] data_in = '1;
  logic        find_success;
  logic [6:0]  pos_out;
  logic [63:0] mask_out;
`ifdef FIRST_ZERO_UPDATED_OUT_EN
  logic [63:0] updated_out;
`endif

  int checks = 0;
  int errors = 0;

  first_zero #(.DATA_WIDTH(64), .POS_WIDTH(7)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .find_success (find_success),
    .pos_out      (pos_out),
`ifdef FIRST_ZERO_UPDATED_OUT_EN
    .updated_out  (updated_out),
`endif
    .mask_out     (mask_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic f,
                         input logic [6:0] p, input logic [63:0] m);
    chk({tag, ".find"}, 64'(find_success), 64'(f));
    chk({tag, ".pos"},  64'(pos_out), 64'(p));
    chk({tag, ".mask"}, mask_out, m);
  endtask

  // Drive at negedge, sample 1 time unit after the following posedge.
  task automatic apply(input logic [63:0] d);
    @(negedge clk);
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic model(input logic [63:0] d, output logic f,
                       output logic [6:0] p, output logic [63:0] m);
    f = 1'b0;
    p = 7'd64;
    m = '0;
    for (int i = 0; i < 64; i++) begin
      if (!f && !d[i]) begin
        f = 1'b1;
        p = 7'(i);
        m = 64'd1 << i;
      end
    end
  endtask

  task automatic chk_upd(input string tag, input logic [63:0] d);
`ifdef FIRST_ZERO_UPDATED_OUT_EN
    chk({tag, ".upd"}, updated_out, d | mask_out);
`else
    if (tag.len() == 0) $display("%h", d);
`endif
  endtask

  initial begin
    logic        ef;
    logic [6:0]  ep;
    logic [63:0] em;
    logic [63:0] d;

    data_in = 64'hFFFF_FFFF_FFFF_FFFF;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_out("reset_hold", 1'b0, 7'd0, 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_out("all_ones", 1'b0, 7'd64, 64'd0);
    chk_upd("all_ones", 64'hFFFF_FFFF_FFFF_FFFF);

    apply(64'hFFFF_FFFF_FFFF_FFFE);
    chk_out("bit0", 1'b1, 7'd0, 64'h0000_0000_0000_0001);
    chk_upd("bit0", 64'hFFFF_FFFF_FFFF_FFFE);

    apply(64'h7FFF_FFFF_FFFF_FFFF);
    chk_out("bit63", 1'b1, 7'd63, 64'h8000_0000_0000_0000);
    chk_upd("bit63", 64'h7FFF_FFFF_FFFF_FFFF);

    apply(64'hFF00_FF00_FF00_FF00);
    chk_out("stripes", 1'b1, 7'd0, 64'h0000_0000_0000_0001);

    apply(64'hFFFF_FFFF_FFEF_FFFF);
    chk_out("bit20", 1'b1, 7'd20, 64'h0000_0000_0010_0000);
    chk_upd("bit20", 64'hFFFF_FFFF_FFEF_FFFF);

    apply(64'h0000_0000_0000_0000);
    chk_out("all_zero", 1'b1, 7'd0, 64'h0000_0000_0000_0001);

    apply(64'hFFFF_FFFF_FFFF_FF7F);
    chk_out("bit7", 1'b1, 7'd7, 64'h0000_0000_0000_0080);

    apply(64'hFFFF_FFFF_FFFF_FEFF);
    chk_out("bit8", 1'b1, 7'd8, 64'h0000_0000_0000_0100);

    apply(64'hFFFF_FFFF_7FFF_FFFF);
    chk_out("bit31", 1'b1, 7'd31, 64'h0000_0000_8000_0000);

    apply(64'h5FFF_FFFF_FFFF_FFFF);
    chk_out("bit61", 1'b1, 7'd61, 64'h2000_0000_0000_0000);

    apply(64'hFFFF_FFFF_FFFF_FFFF);
    chk_out("back_to_ones", 1'b0, 7'd64, 64'd0);

    for (int n = 0; n < 400; n++) begin
      d = {$urandom, $urandom} | {$urandom, $urandom} | {$urandom, $urandom};
      if (n % 4 == 1) d = ~(64'd1 << $urandom_range(63)) | {$urandom, $urandom};
      if (n % 37 == 5) d = '1;
      apply(d);
      model(d, ef, ep, em);
      chk_out("rand", ef, ep, em);
      chk("rand.inv_and", mask_out & d, 64'd0);
      chk_upd("rand", d);
    end

    apply(64'hFFFF_FFFF_FFFF_FFFE);
    chk_out("pre_rst", 1'b1, 7'd0, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 7'd0, 64'd0);
    @(posedge clk);
    #1;
    chk_out("rst_hold", 1'b0, 7'd0, 64'd0);

    @(negedge clk);
    data_in = 64'hFFFF_FFFF_FFFF_F0FF;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_out("post_release", 1'b1, 7'd8, 64'h0000_0000_0000_0100);
    chk_upd("post_release", 64'hFFFF_FFFF_FFFF_F0FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
